// File: rtl/mem_port_arbiter_if.sv
// Bundle of the instruction-fetch, data-memory and unified memory port signals
// shared between the arbiter (slave) and the core/memory environment (master).
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;

  logic              dm_req;
  logic [3:0]        dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall;
  logic              grant_dm;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
    output if_rdata, if_valid, dm_rdata, dm_valid, mem_req, mem_addr, mem_we, mem_wdata,
           stall, grant_dm
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
    input  if_rdata, if_valid, dm_rdata, dm_valid, mem_req, mem_addr, mem_we, mem_wdata,
           stall, grant_dm
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and the
// load/store path, sequencing each access through a req/ack handshake.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_LIM = 3
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  mem_port_arbiter_if.slave       port_io
);

  typedef enum logic [1:0] {StIdle, StIfBusy, StDmBusy} state_e;

  localparam logic [3:0] StarveLim = 4'(STARVE_LIM);

  state_e            state_q;
  logic [3:0]        starve_cnt_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_valid_q;
  logic              dm_valid_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              grant_dm_q;

  logic if_elig;
  logic dm_elig;
  logic if_starved;

  // A req seen during its own valid cycle still belongs to the finished access.
  assign if_elig    = port_io.if_req & ~if_valid_q;
  assign dm_elig    = port_io.dm_req & ~dm_valid_q;
  assign if_starved = if_elig & (starve_cnt_q == StarveLim);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      starve_cnt_q <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= '0;
      mem_wdata_q  <= '0;
      if_valid_q   <= 1'b0;
      dm_valid_q   <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      grant_dm_q   <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (dm_elig && !if_starved) begin
            state_q     <= StDmBusy;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= port_io.dm_addr;
            mem_we_q    <= port_io.dm_we;
            mem_wdata_q <= port_io.dm_wdata;
            grant_dm_q  <= 1'b1;
            if (!if_elig) begin
              starve_cnt_q <= '0;
            end else if (starve_cnt_q != StarveLim) begin
              starve_cnt_q <= starve_cnt_q + 4'd1;
            end
          end else if (if_elig) begin
            state_q      <= StIfBusy;
            mem_req_q    <= 1'b1;
            mem_addr_q   <= port_io.if_addr;
            mem_we_q     <= '0;
            starve_cnt_q <= '0;
          end else begin
            mem_req_q <= 1'b0;
          end
        end
        StIfBusy, StDmBusy: begin
          if (port_io.mem_ack) begin
            state_q    <= StIdle;
            mem_req_q  <= 1'b0;
            grant_dm_q <= 1'b0;
            if (state_q == StIfBusy) begin
              if_rdata_q <= port_io.mem_rdata;
              if_valid_q <= 1'b1;
            end else begin
              dm_valid_q <= 1'b1;
              // Stores complete without disturbing the last load result.
              if (mem_we_q == 4'b0000) begin
                dm_rdata_q <= port_io.mem_rdata;
              end
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign port_io.mem_req   = mem_req_q;
  assign port_io.mem_addr  = mem_addr_q;
  assign port_io.mem_we    = mem_we_q;
  assign port_io.mem_wdata = mem_wdata_q;
  assign port_io.if_valid  = if_valid_q;
  assign port_io.if_rdata  = if_rdata_q;
  assign port_io.dm_valid  = dm_valid_q;
  assign port_io.dm_rdata  = dm_rdata_q;
  assign port_io.grant_dm  = grant_dm_q;

  assign port_io.stall = (port_io.if_req & ~if_valid_q) | (port_io.dm_req & ~dm_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a random
// run compared against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LIM = 3;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .port_io (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired: got timeout, required completion");
    $fatal(1);
  end

  // Reference model: owner 0 = none, 1 = fetch, 2 = data.
  int unsigned     m_owner = 0;
  int unsigned     m_starve = 0;
  logic            exp_mem_req = 1'b0;
  logic [AW-1:0]   exp_mem_addr = '0;
  logic [3:0]      exp_mem_we = '0;
  logic [DW-1:0]   exp_mem_wdata = '0;
  logic            exp_if_valid = 1'b0;
  logic            exp_dm_valid = 1'b0;
  logic [DW-1:0]   exp_if_rdata = '0;
  logic [DW-1:0]   exp_dm_rdata = '0;
  logic            exp_grant = 1'b0;

  task automatic model_update();
    logic ife, dme;
    if (reset) begin
      m_owner = 0; m_starve = 0;
      exp_mem_req = 1'b0; exp_mem_addr = '0; exp_mem_we = '0; exp_mem_wdata = '0;
      exp_if_valid = 1'b0; exp_dm_valid = 1'b0; exp_if_rdata = '0; exp_dm_rdata = '0;
      exp_grant = 1'b0;
    end else begin
      ife = bus.if_req && !exp_if_valid;
      dme = bus.dm_req && !exp_dm_valid;
      exp_if_valid = 1'b0;
      exp_dm_valid = 1'b0;
      if (m_owner == 0) begin
        if (dme && !(ife && m_starve == LIM)) begin
          m_owner = 2;
          exp_mem_req = 1'b1; exp_grant = 1'b1;
          exp_mem_addr = bus.dm_addr; exp_mem_we = bus.dm_we; exp_mem_wdata = bus.dm_wdata;
          m_starve = ife ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
        end else if (ife) begin
          m_owner = 1;
          exp_mem_req = 1'b1;
          exp_mem_addr = bus.if_addr; exp_mem_we = 4'b0000;
          m_starve = 0;
        end else begin
          exp_mem_req = 1'b0;
        end
      end else if (bus.mem_ack) begin
        if (m_owner == 1) begin
          exp_if_rdata = bus.mem_rdata; exp_if_valid = 1'b1;
        end else begin
          exp_dm_valid = 1'b1;
          if (exp_mem_we == 4'b0000) exp_dm_rdata = bus.mem_rdata;
        end
        m_owner = 0; exp_mem_req = 1'b0; exp_grant = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.if_valid, bus.dm_valid,
         bus.if_rdata, bus.dm_rdata, bus.grant_dm, bus.stall} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b we=%h addr=%h wd=%h iv=%b dv=%b ird=%h drd=%h g=%b st=%b required all 0",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.if_valid, bus.dm_valid,
               bus.if_rdata, bus.dm_rdata, bus.grant_dm, bus.stall);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_idle got mem_req=%b required 0", bus.mem_req);
    end
  endtask

  task automatic test_if_only();
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0100;
    tick();
    checks++;
    if ({bus.mem_req, bus.mem_addr, bus.mem_we, bus.grant_dm, bus.stall, bus.if_valid}
        !== {1'b1, 32'h0000_0100, 4'b0000, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL if_grant got req=%b addr=%h we=%b g=%b st=%b iv=%b required 1 00000100 0000 0 1 0",
               bus.mem_req, bus.mem_addr, bus.mem_we, bus.grant_dm, bus.stall, bus.if_valid);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0013;
    tick();
    checks++;
    if ({bus.if_valid, bus.if_rdata, bus.stall, bus.mem_req} !== {1'b1, 32'h13, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL if_valid_cycle got iv=%b rd=%h st=%b req=%b required 1 00000013 0 0",
               bus.if_valid, bus.if_rdata, bus.stall, bus.mem_req);
    end
    bus.mem_ack = 1'b0; bus.if_req = 1'b0;
    tick();
    checks++;
    if ({bus.if_valid, bus.mem_req} !== 2'b00) begin
      errors++;
      $display("FAIL if_pulse_width got iv=%b req=%b required 0 0", bus.if_valid, bus.mem_req);
    end
  endtask

  task automatic test_simultaneous();
    int reqcyc = 0;
    int dm_at = -1;
    int if_at = -1;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0400;
    bus.dm_req = 1'b1; bus.dm_we = 4'b0000; bus.dm_addr = 32'h0000_0200;
    for (int c = 1; c <= 40 && if_at < 0; c++) begin
      tick();
      if (bus.mem_req) reqcyc++; else reqcyc = 0;
      if (c == 1) begin
        checks++;
        if ({bus.grant_dm, bus.mem_addr} !== {1'b1, 32'h0000_0200}) begin
          errors++;
          $display("FAIL simul_dm_first got g=%b addr=%h required 1 00000200",
                   bus.grant_dm, bus.mem_addr);
        end
      end
      if (bus.dm_valid) begin dm_at = c; bus.dm_req = 1'b0; end
      if (bus.if_valid) begin if_at = c; bus.if_req = 1'b0; end
      bus.mem_ack   = (reqcyc == 3);
      bus.mem_rdata = bus.grant_dm ? 32'hDEAD_0200 : 32'h0000_0513;
    end
    bus.mem_ack = 1'b0;
    checks++;
    if (dm_at !== 4) begin
      errors++; $display("FAIL simul_dm_valid_cycle got %0d required 4", dm_at);
    end
    checks++;
    if (if_at !== 8) begin
      errors++; $display("FAIL simul_if_valid_cycle got %0d required 8", if_at);
    end
    checks++;
    if ({bus.dm_rdata, bus.if_rdata} !== {32'hDEAD_0200, 32'h0000_0513}) begin
      errors++;
      $display("FAIL simul_rdata got dm=%h if=%h required DEAD0200 00000513",
               bus.dm_rdata, bus.if_rdata);
    end
    tick();
  endtask

  task automatic test_store();
    int reqcyc = 0;
    int pulses = 0;
    bus.dm_req = 1'b1; bus.dm_we = 4'b0100; bus.dm_wdata = 32'h00AB_0000;
    bus.dm_addr = 32'h0000_0304;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (bus.mem_req) begin
        reqcyc++;
        checks++;
        if ({bus.mem_addr, bus.mem_we, bus.mem_wdata} !== {32'h304, 4'b0100, 32'h00AB_0000}) begin
          errors++;
          $display("FAIL store_hold cyc %0d got addr=%h we=%b wd=%h required 00000304 0100 00ab0000",
                   c, bus.mem_addr, bus.mem_we, bus.mem_wdata);
        end
      end
      if (bus.dm_valid) begin
        pulses++;
        bus.dm_req = 1'b0;
        checks++;
        if (bus.dm_rdata !== 32'hDEAD_0200) begin
          errors++; $display("FAIL store_rdata_kept got %h required DEAD0200", bus.dm_rdata);
        end
      end
      bus.mem_ack   = bus.mem_req && (reqcyc == 2);
      bus.mem_rdata = 32'h1234_5678;
    end
    bus.mem_ack = 1'b0;
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL store_valid_pulses got %0d required 1", pulses);
    end
  endtask

  task automatic test_back_to_back();
    int  ngrant = 0;
    int  lowrun = 0;
    logic prev = 1'b0;
    logic [3:0] order = '0;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_1000;
    bus.dm_req = 1'b1; bus.dm_we = 4'b0000; bus.dm_addr = 32'h0000_2000;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (bus.mem_req && !prev) begin
        if (ngrant < 4) order[3 - ngrant] = bus.grant_dm;
        if (ngrant > 0) begin
          checks++;
          if (lowrun !== 1) begin
            errors++; $display("FAIL b2b_gap grant %0d got %0d idle cycles required 1", ngrant, lowrun);
          end
        end
        checks++;
        if (bus.mem_addr !== (bus.grant_dm ? 32'h0000_2000 : 32'h0000_1000)) begin
          errors++; $display("FAIL b2b_addr grant %0d got %h", ngrant, bus.mem_addr);
        end
        ngrant++;
      end
      lowrun = bus.mem_req ? 0 : lowrun + 1;
      prev = bus.mem_req;
      bus.mem_ack = bus.mem_req;
    end
    checks++;
    if (order !== 4'b1010) begin
      errors++; $display("FAIL b2b_order got %b required 1010", order);
    end
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      bus.mem_ack = bus.mem_req;
    end
    bus.mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.dm_req = 1'b1; bus.dm_we = 4'b0000; bus.dm_addr = 32'h0000_0380;
    tick();
    checks++;
    if (bus.mem_req !== 1'b1) begin
      errors++; $display("FAIL midrst_busy got mem_req=%b required 1", bus.mem_req);
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.mem_req, bus.dm_valid, bus.grant_dm} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_abort got req=%b dv=%b g=%b required 0 0 0",
               bus.mem_req, bus.dm_valid, bus.grant_dm);
    end
    reset = 1'b0; bus.dm_req = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    tick();
    checks++;
    if ({bus.dm_valid, bus.if_valid, bus.mem_req, bus.dm_rdata} !== {3'b000, 32'h0}) begin
      errors++;
      $display("FAIL midrst_late_ack got dv=%b iv=%b req=%b drd=%h required 0 0 0 00000000",
               bus.dm_valid, bus.if_valid, bus.mem_req, bus.dm_rdata);
    end
    bus.mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_spurious_held();
    bus.mem_ack = 1'b1;
    tick(); tick();
    checks++;
    if ({bus.if_valid, bus.dm_valid, bus.mem_req} !== 3'b000) begin
      errors++;
      $display("FAIL spurious_ack got iv=%b dv=%b req=%b required 0 0 0",
               bus.if_valid, bus.dm_valid, bus.mem_req);
    end
    bus.mem_ack = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0500;
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0093;
    tick();
    checks++;
    if ({bus.if_valid, bus.mem_req, bus.if_rdata} !== {2'b10, 32'h93}) begin
      errors++;
      $display("FAIL held_valid got iv=%b req=%b rd=%h required 1 0 00000093",
               bus.if_valid, bus.mem_req, bus.if_rdata);
    end
    bus.mem_ack = 1'b0; bus.if_addr = 32'h0000_0504;
    tick();
    checks++;
    if ({bus.if_valid, bus.mem_req} !== 2'b00) begin
      errors++; $display("FAIL held_no_regrant got iv=%b req=%b required 0 0", bus.if_valid, bus.mem_req);
    end
    tick();
    checks++;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h0000_0504}) begin
      errors++;
      $display("FAIL held_next_fetch got req=%b addr=%h required 1 00000504", bus.mem_req, bus.mem_addr);
    end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0; bus.if_req = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      tick();
      checks++;
      if ({bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.grant_dm} !==
          {exp_mem_req, exp_mem_addr, exp_mem_we, exp_mem_wdata, exp_grant}) begin
        errors++;
        $display("FAIL rand_mem cyc %0d got req=%b addr=%h we=%b wd=%h g=%b required %b %h %b %h %b",
                 c, bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.grant_dm,
                 exp_mem_req, exp_mem_addr, exp_mem_we, exp_mem_wdata, exp_grant);
      end
      checks++;
      if ({bus.if_valid, bus.if_rdata, bus.dm_valid, bus.dm_rdata} !==
          {exp_if_valid, exp_if_rdata, exp_dm_valid, exp_dm_rdata}) begin
        errors++;
        $display("FAIL rand_resp cyc %0d got iv=%b ird=%h dv=%b drd=%h required %b %h %b %h",
                 c, bus.if_valid, bus.if_rdata, bus.dm_valid, bus.dm_rdata,
                 exp_if_valid, exp_if_rdata, exp_dm_valid, exp_dm_rdata);
      end
      checks++;
      if (bus.stall !== ((bus.if_req && !exp_if_valid) || (bus.dm_req && !exp_dm_valid))) begin
        errors++;
        $display("FAIL rand_stall cyc %0d got %b ifreq=%b dmreq=%b", c, bus.stall, bus.if_req, bus.dm_req);
      end
      if (!bus.if_req) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.if_req = 1'b1; bus.if_addr = $urandom;
        end
      end else if (exp_if_valid) begin
        if ($urandom_range(0, 1) == 1) bus.if_addr = $urandom;
        else bus.if_req = 1'b0;
      end
      if (!bus.dm_req || exp_dm_valid) begin
        if (!bus.dm_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 1) == 1)) begin
          bus.dm_req   = 1'b1;
          bus.dm_addr  = $urandom;
          bus.dm_wdata = $urandom;
          bus.dm_we    = ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'($urandom_range(1, 15));
        end else begin
          bus.dm_req = 1'b0;
        end
      end
      bus.mem_ack   = ($urandom_range(0, 2) == 0);
      bus.mem_rdata = $urandom;
      reset         = ($urandom_range(0, 249) == 0);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    @(negedge clk);
    test_reset();
    test_if_only();
    test_simultaneous();
    test_store();
    test_back_to_back();
    test_reset_mid();
    test_spurious_held();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
